hub75_scan_driver: RTL and testbench

HUB75_SCAN_DRIVER -- requirements
Module: hub75_scan_driver

---
 rtl/hub75_pkg.sv | 8 +
 rtl/hub75_bcm_timer.sv | 29 ++
 rtl/hub75_scan_driver.sv | 120 ++++++++++++
 tb/tb_hub75_scan_driver.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// hub75_pkg: shared FSM state encoding and bit-plane (BCM) display length for the HUB75 scan driver.
package hub75_pkg;
    typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, SHOW} state_t;

    function automatic int bcm_len(input int base, input int plane);
        return base << plane;
    endfunction
endpackage

// File: rtl/hub75_bcm_timer.sv
// hub75_bcm_timer: loadable down-counter timing one SHOW period; done pulses in its last cycle.
module hub75_bcm_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] len_m1,
    output logic         done
);
    logic [W-1:0] cnt;
    logic         run;

    assign done = run && cnt == '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (load) begin
            cnt <= len_m1;
            run <= 1'b1;
        end else if (done) begin
            run <= 1'b0;
        end else if (run) begin
            cnt <= cnt - W'(1);
        end
    end
endmodule

// File: rtl/hub75_scan_driver.sv
// hub75_scan_driver: HUB75 panel scanner with binary-coded modulation, one bit-plane per row pass.
module hub75_scan_driver
    import hub75_pkg::*;
#(
    parameter int COLS       = 64,
    parameter int ROW_BITS   = 4,
    parameter int BPC        = 4,
    parameter int BASE_TICKS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    output logic [ROW_BITS-1:0]      rd_row,
    output logic [$clog2(COLS)-1:0]  rd_col,
    input  logic [3*BPC-1:0]         rd_data0,
    input  logic [3*BPC-1:0]         rd_data1,
    output logic                     R0,
    output logic                     G0,
    output logic                     B0,
    output logic                     R1,
    output logic                     G1,
    output logic                     B1,
    output logic                     SCLK,
    output logic                     LAT,
    output logic                     OE,
    output logic [ROW_BITS-1:0]      addr,
    output logic                     frame_start
);
    localparam int CW = $clog2(COLS);
    localparam int PW = BPC > 1 ? $clog2(BPC) : 1;
    localparam int TW = $clog2(bcm_len(BASE_TICKS, BPC - 1) + 1);

    state_t                state, state_n;
    logic [CW-1:0]         col, col_n, col_nx;
    logic                  phase, phase_n;
    logic [PW-1:0]         plane, plane_n;
    logic [ROW_BITS-1:0]   row, row_n;
    logic                  armed, load, done;
    logic [TW-1:0]         len_m1;
    logic [3*BPC-1:0]      d0, d1;

    assign len_m1 = TW'(bcm_len(BASE_TICKS, int'(plane)) - 1);
    assign col_nx = (col_n == CW'(COLS - 1)) ? '0 : col_n + CW'(1);
    assign d0     = rd_data0 >> plane;
    assign d1     = rd_data1 >> plane;

    // Pass pointer (plane/row) advances as SHOW begins so the next pass is already addressed during SHOW.
    always_comb begin
        state_n = state;
        col_n   = col;
        phase_n = phase;
        plane_n = plane;
        row_n   = row;
        load    = 1'b0;
        case (state)
            IDLE:  state_n = (en && armed) ? SHIFT : IDLE;
            SHIFT: begin
                phase_n = ~phase;
                if (phase) begin
                    col_n   = (col == CW'(COLS - 1)) ? '0 : col + CW'(1);
                    state_n = (col == CW'(COLS - 1)) ? BLANK : SHIFT;
                end
            end
            BLANK: state_n = LATCH;
            LATCH: begin
                state_n = SHOW;
                load    = 1'b1;
                plane_n = (plane == PW'(BPC - 1)) ? '0 : plane + PW'(1);
                row_n   = (plane == PW'(BPC - 1)) ? row + ROW_BITS'(1) : row;
            end
            SHOW:    state_n = done ? (en ? SHIFT : IDLE) : SHOW;
            default: state_n = IDLE;
        endcase
    end

    hub75_bcm_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .len_m1 (len_m1),
        .done   (done)
    );

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            col         <= '0;
            phase       <= 1'b0;
            plane       <= '0;
            row         <= '0;
            armed       <= 1'b0;
            rd_row      <= '0;
            rd_col      <= '0;
            {R0, G0, B0, R1, G1, B1} <= '0;
            SCLK        <= 1'b0;
            LAT         <= 1'b0;
            OE          <= 1'b1;
            addr        <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            col         <= col_n;
            phase       <= phase_n;
            plane       <= plane_n;
            row         <= row_n;
            armed       <= 1'b1;
            rd_row      <= row_n;
            rd_col      <= (state_n != SHIFT) ? '0 : (phase_n ? col_nx : col_n);
            SCLK        <= state_n == SHIFT && phase_n;
            LAT         <= state_n == LATCH;
            OE          <= state_n != SHOW;
            frame_start <= state_n == SHIFT && state != SHIFT && row == '0 && plane == '0;
            if (state_n == LATCH)
                addr <= row;
            if (state_n == SHIFT && !phase_n)
                {R0, G0, B0, R1, G1, B1} <= {d0[2*BPC], d0[BPC], d0[0], d1[2*BPC], d1[BPC], d1[0]};
        end
    end
endmodule

// File: tb/tb_hub75_scan_driver.sv
// tb_hub75_scan_driver: directed pass sequence with random framebuffer, checked against a per-pass panel model.
module tb_hub75_scan_driver;
    logic       clk = 1'b0;
    logic       rst_n, en;
    logic [1:0] rd_row, rd_col, addr;
    logic [5:0] rd_data0, rd_data1;
    logic       R0, G0, B0, R1, G1, B1, SCLK, LAT, OE, frame_start;
    logic [5:0] fb0 [4][4];
    logic [5:0] fb1 [4][4];
    int         tests, fails, pass_no;

    always #5 clk = ~clk;

    assign rd_data0 = fb0[rd_row][rd_col];
    assign rd_data1 = fb1[rd_row][rd_col];

    hub75_scan_driver #(.COLS(4), .ROW_BITS(2), .BPC(2), .BASE_TICKS(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .rd_row      (rd_row),
        .rd_col      (rd_col),
        .rd_data0    (rd_data0),
        .rd_data1    (rd_data1),
        .R0          (R0),
        .G0          (G0),
        .B0          (B0),
        .R1          (R1),
        .G1          (G1),
        .B1          (B1),
        .SCLK        (SCLK),
        .LAT         (LAT),
        .OE          (OE),
        .addr        (addr),
        .frame_start (frame_start)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_fb(input bit force_r01);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                fb0[r][c] = 6'($urandom);
                fb1[r][c] = 6'($urandom);
                if (force_r01) fb0[r][c][5:4] = 2'b01;
            end
    endtask

    task automatic chk_reset();
        chk("rst_oe", OE, 1);
        chk("rst_lat", LAT, 0);
        chk("rst_sclk", SCLK, 0);
        chk("rst_addr", addr, 0);
        chk("rst_rd_row", rd_row, 0);
        chk("rst_rd_col", rd_col, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_rgb", {R0, G0, B0, R1, G1, B1}, 0);
    endtask

    task automatic chk_idle();
        chk("idle_oe", OE, 1);
        chk("idle_sclk", SCLK, 0);
        chk("idle_lat", LAT, 0);
        chk("idle_fs", frame_start, 0);
    endtask

    function automatic logic [5:0] rgb_bits(input int row, input int c, input int pl);
        return {fb0[row][c][4+pl], fb0[row][c][2+pl], fb0[row][c][pl],
                fb1[row][c][4+pl], fb1[row][c][2+pl], fb1[row][c][pl]};
    endfunction

    // One row pass: pass n shows plane n%2 of row (n/2)%4; SHOW lasts BASE_TICKS<<plane cycles.
    task automatic run_pass(input bit drop_en, input bit abort);
        int row, pl, len;
        row = (pass_no / 2) % 4;
        pl  = pass_no % 2;
        len = 2 << pl;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("sclk", SCLK, k % 2);
            chk("oe_shift", OE, 1);
            chk("lat_shift", LAT, 0);
            chk("frame_start", frame_start, (k == 0 && row == 0 && pl == 0) ? 1 : 0);
            chk("rgb", {R0, G0, B0, R1, G1, B1}, rgb_bits(row, k / 2, pl));
            if (drop_en && k == 3) en = 1'b0;
        end
        step();
        chk("blank_oe", OE, 1);
        chk("blank_lat", LAT, 0);
        chk("blank_sclk", SCLK, 0);
        step();
        chk("latch_lat", LAT, 1);
        chk("latch_oe", OE, 1);
        chk("latch_addr", addr, row);
        for (int s = 0; s < len; s++) begin
            step();
            chk("show_oe", OE, 0);
            chk("show_lat", LAT, 0);
            chk("show_sclk", SCLK, 0);
            chk("show_addr", addr, row);
            chk("show_rgb_hold", {R0, G0, B0, R1, G1, B1}, rgb_bits(row, 3, pl));
            if (abort && s == 1) begin
                rst_n = 1'b0;
                #1;
                chk_reset();
                return;
            end
        end
        pass_no++;
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        pass_no = 0;
        rst_n   = 1'b0;
        en      = 1'b1;
        fill_fb(1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_idle();
        for (int p = 0; p < 9; p++) run_pass(1'b0, 1'b0);
        fill_fb(1'b0);
        run_pass(1'b0, 1'b0);
        run_pass(1'b1, 1'b0);
        repeat (3) begin
            step();
            chk_idle();
        end
        en = 1'b1;
        run_pass(1'b0, 1'b0);
        run_pass(1'b0, 1'b1);
        pass_no = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_idle();
        run_pass(1'b0, 1'b0);
        run_pass(1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
